// File: rtl/load_use_interlock_pkg.sv
// Shared definitions for the load-use interlock: load opcode, index/counter widths, FSM states.
package load_use_interlock_pkg;
   localparam logic [3:0] OP_LOAD   = 4'b1110;
   localparam int         REG_IDX_W = 3;
   localparam int         CNT_W     = 3;

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } state_e;
endpackage

// File: rtl/load_timer.sv
// Countdown timer for one register's pending load; busy while nonzero.
module load_timer
   import load_use_interlock_pkg::*;
#(
   parameter int LOAD_LAT = 2
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clr_i,
   input  logic load_i,
   output logic busy_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Clear beats reload, and reload beats the natural decrement.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (load_i)
         cnt_d = CNT_W'(LOAD_LAT);
      else if (cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/load_use_interlock.sv
// Load-use interlock between decode and execute: stalls readers of pending load results.
// Optional stall statistics counter enabled by defining LUI_STALL_STATS_EN.
module load_use_interlock
   import load_use_interlock_pkg::*;
#(
   parameter int LOAD_LAT = 2,
   parameter int NREG     = 8
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 issue_valid,
   input  logic [3:0]           issue_op,
   input  logic [REG_IDX_W-1:0] issue_dst,
   input  logic [REG_IDX_W-1:0] issue_src_a,
   input  logic [REG_IDX_W-1:0] issue_src_b,
   input  logic [1:0]           issue_src_en,
   input  logic                 flush,
`ifdef LUI_STALL_STATS_EN
   input  logic                 stats_clr,
   output logic [15:0]          stall_count,
`endif
   output logic                 stall,
   output logic                 bubble,
   output logic [NREG-1:0]      busy_vec
);

   logic   hit_a, hit_b, accept, is_load;
   state_e state_q, state_d;

   assign hit_a   = issue_src_en[0] & busy_vec[issue_src_a];
   assign hit_b   = issue_src_en[1] & busy_vec[issue_src_b];
   assign stall   = issue_valid & ~flush & (hit_a | hit_b);
   assign accept  = issue_valid & ~stall & ~flush;
   assign is_load = (issue_op == OP_LOAD);

   // r0 is hardwired zero, so it never has a timer.
   assign busy_vec[0] = 1'b0;

   for (genvar r = 1; r < NREG; r++) begin : g_tmr
      load_timer #(.LOAD_LAT(LOAD_LAT)) u_tmr (
         .clock  (clock),
         .reset_n(reset_n),
         .clr_i  (flush),
         .load_i (accept & is_load & (issue_dst == REG_IDX_W'(r))),
         .busy_o (busy_vec[r])
      );
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (stall) state_d = HOLD;
         HOLD:    if (!stall || flush) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         state_q <= RUN;
      else
         state_q <= state_d;
   end

   // HOLD is entered exactly on the edge after a stall cycle, so it doubles as the bubble flag.
   assign bubble = (state_q == HOLD);

`ifdef LUI_STALL_STATS_EN
   logic [15:0] stall_cnt_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         stall_cnt_q <= '0;
      else if (stats_clr)
         stall_cnt_q <= '0;
      else if (stall && (stall_cnt_q != 16'hFFFF))
         stall_cnt_q <= stall_cnt_q + 16'd1;
   end

   assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_load_use_interlock.sv
// Scoreboard bench for load_use_interlock with LOAD_LAT=2, NREG=8.
module tb_load_use_interlock;
   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       issue_valid = 1'b0;
   logic [3:0] issue_op = '0;
   logic [2:0] issue_dst = '0, issue_src_a = '0, issue_src_b = '0;
   logic [1:0] issue_src_en = '0;
   logic       flush = 1'b0;
   logic       stall, bubble;
   logic [7:0] busy_vec;
`ifdef LUI_STALL_STATS_EN
   logic        stats_clr = 1'b0;
   logic [15:0] stall_count;
`endif

   load_use_interlock #(.LOAD_LAT(2), .NREG(8)) dut (
      .clock(clock), .reset_n(reset_n), .issue_valid(issue_valid), .issue_op(issue_op),
      .issue_dst(issue_dst), .issue_src_a(issue_src_a), .issue_src_b(issue_src_b),
      .issue_src_en(issue_src_en), .flush(flush),
`ifdef LUI_STALL_STATS_EN
      .stats_clr(stats_clr), .stall_count(stall_count),
`endif
      .stall(stall), .bubble(bubble), .busy_vec(busy_vec)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       s;
      logic       b;
      logic [7:0] busy;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   exp_stalls = 0;

   localparam logic [3:0] LD = 4'b1110;
   localparam logic [3:0] AD = 4'b0000;

   always @(negedge clock) begin
      exp_t e;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         n_vec++;
         if (stall !== e.s || bubble !== e.b || busy_vec !== e.busy) begin
            n_err++;
            $display("FAIL %s: stall/bubble/busy_vec got %b/%b/%h, want %b/%b/%h",
                     e.name, stall, bubble, busy_vec, e.s, e.b, e.busy);
         end
      end
   end

   task automatic cyc(input logic rn, input logic v, input logic [3:0] op, input logic [2:0] d,
                      input logic [2:0] sa, input logic [2:0] sbr, input logic [1:0] en,
                      input logic fl, input logic es, input logic eb, input logic [7:0] ebusy,
                      input string nm);
      exp_t e;
      @(posedge clock);
      #1;
      reset_n = rn; issue_valid = v; issue_op = op; issue_dst = d;
      issue_src_a = sa; issue_src_b = sbr; issue_src_en = en; flush = fl;
      e.s = es; e.b = eb; e.busy = ebusy; e.name = nm;
      sb.push_back(e);
      if (es) exp_stalls++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      n_err++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "timeout");
   end

   initial begin
      // reset held with random inputs
      for (int i = 0; i < 3; i++)
         cyc(0, 1'($urandom), 4'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
             2'($urandom), 1'($urandom), 0, 0, 8'h00, "reset");
      cyc(1, 1, AD, 1, 7, 6, 2'b11, 0, 0, 0, 8'h00, "post_reset_nostall");
      // load-use hazard
      cyc(1, 1, LD, 3, 0, 0, 2'b00, 0, 0, 0, 8'h00, "lu_load_r3");
      cyc(1, 1, AD, 1, 3, 0, 2'b01, 0, 1, 0, 8'h08, "lu_stall1");
      cyc(1, 1, AD, 1, 3, 0, 2'b01, 0, 1, 1, 8'h08, "lu_stall2");
      cyc(1, 1, AD, 1, 3, 0, 2'b01, 0, 0, 1, 8'h00, "lu_accept");
      cyc(1, 0, AD, 0, 0, 0, 2'b00, 0, 0, 0, 8'h00, "lu_idle");
      // non-hazard reads
      cyc(1, 1, LD, 3, 0, 0, 2'b00, 0, 0, 0, 8'h00, "nh_load_r3");
      cyc(1, 1, AD, 1, 4, 5, 2'b11, 0, 0, 0, 8'h08, "nh_r4_r5");
      cyc(1, 1, AD, 1, 3, 3, 2'b00, 0, 0, 0, 8'h08, "nh_en00");
      cyc(1, 0, AD, 0, 0, 0, 2'b00, 0, 0, 0, 8'h00, "nh_idle");
      // register 0
      cyc(1, 1, LD, 0, 0, 0, 2'b00, 0, 0, 0, 8'h00, "r0_load");
      cyc(1, 1, AD, 1, 0, 0, 2'b11, 0, 0, 0, 8'h00, "r0_read");
      cyc(1, 0, AD, 0, 0, 0, 2'b00, 0, 0, 0, 8'h00, "r0_idle");
      // flush mid-stall
      cyc(1, 1, LD, 2, 0, 0, 2'b00, 0, 0, 0, 8'h00, "fl_load_r2");
      cyc(1, 1, AD, 1, 2, 0, 2'b01, 0, 1, 0, 8'h04, "fl_stall");
      cyc(1, 1, AD, 1, 2, 0, 2'b01, 1, 0, 1, 8'h04, "fl_flush");
      cyc(1, 1, AD, 1, 2, 0, 2'b01, 0, 0, 0, 8'h00, "fl_after");
      // reload of a busy register
      cyc(1, 1, LD, 6, 0, 0, 2'b00, 0, 0, 0, 8'h00, "rl_load1");
      cyc(1, 1, LD, 6, 0, 0, 2'b00, 0, 0, 0, 8'h40, "rl_load2");
      cyc(1, 0, AD, 0, 0, 0, 2'b00, 0, 0, 0, 8'h40, "rl_t2");
      cyc(1, 0, AD, 0, 0, 0, 2'b00, 0, 0, 0, 8'h40, "rl_t3");
      cyc(1, 0, AD, 0, 0, 0, 2'b00, 0, 0, 0, 8'h00, "rl_t4");
      // back-to-back loads to different registers, hazard on src_b
      cyc(1, 1, LD, 1, 0, 0, 2'b00, 0, 0, 0, 8'h00, "bb_load_r1");
      cyc(1, 1, LD, 5, 0, 0, 2'b00, 0, 0, 0, 8'h02, "bb_load_r5");
      cyc(1, 0, AD, 0, 0, 0, 2'b00, 0, 0, 0, 8'h22, "bb_both");
      cyc(1, 1, AD, 1, 0, 5, 2'b10, 0, 1, 0, 8'h20, "bb_stall_b");
      cyc(1, 1, AD, 1, 0, 5, 2'b10, 0, 0, 1, 8'h00, "bb_accept");
      cyc(1, 0, AD, 0, 0, 0, 2'b00, 0, 0, 0, 8'h00, "bb_idle");
      // reload coinciding with expiry
      cyc(1, 1, LD, 4, 0, 0, 2'b00, 0, 0, 0, 8'h00, "ex_load1");
      cyc(1, 0, AD, 0, 0, 0, 2'b00, 0, 0, 0, 8'h10, "ex_cnt2");
      cyc(1, 1, LD, 4, 0, 0, 2'b00, 0, 0, 0, 8'h10, "ex_reload");
      cyc(1, 0, AD, 0, 0, 0, 2'b00, 0, 0, 0, 8'h10, "ex_cnt2b");
      cyc(1, 0, AD, 0, 0, 0, 2'b00, 0, 0, 0, 8'h10, "ex_cnt1");
      cyc(1, 0, AD, 0, 0, 0, 2'b00, 0, 0, 0, 8'h00, "ex_done");
`ifdef LUI_STALL_STATS_EN
      @(negedge clock); #1;
      n_vec++;
      if (stall_count !== 16'(exp_stalls)) begin
         n_err++;
         $display("FAIL stall_count: got %0d, want %0d", stall_count, exp_stalls);
      end
      stats_clr = 1'b1;
      cyc(1, 0, AD, 0, 0, 0, 2'b00, 0, 0, 0, 8'h00, "st_clr");
      stats_clr = 1'b0;
      cyc(1, 0, AD, 0, 0, 0, 2'b00, 0, 0, 0, 8'h00, "st_after");
      @(negedge clock); #1;
      n_vec++;
      if (stall_count !== 16'd0) begin
         n_err++;
         $display("FAIL stall_count_clr: got %0d, want 0", stall_count);
      end
`endif
      // asynchronous reset in the middle of a stall
      cyc(1, 1, LD, 7, 0, 0, 2'b00, 0, 0, 0, 8'h00, "rs_load_r7");
      cyc(1, 1, AD, 1, 7, 0, 2'b01, 0, 1, 0, 8'h80, "rs_stall");
      cyc(0, 1, AD, 1, 7, 0, 2'b01, 0, 0, 0, 8'h00, "rs_reset");
      cyc(0, 1, AD, 1, 7, 0, 2'b01, 0, 0, 0, 8'h00, "rs_hold");
      cyc(1, 1, AD, 1, 7, 0, 2'b01, 0, 0, 0, 8'h00, "rs_release");
      @(negedge clock); #1;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
